// File: rtl/ook_modulator.sv
// On-off-keying transmit modulator: frames each accepted word as preamble, start,
// LSB-first data and stop symbols, keying a free-running carrier onto mod_out.
module ook_modulator #(
    parameter int DATA_WIDTH    = 8,
    parameter int CLKS_PER_BIT  = 16,
    parameter int CARRIER_DIV   = 4,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  mod_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BIT_MAX = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
    localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
    localparam int CLK_W   = $clog2(CLKS_PER_BIT);
    localparam int CAR_W   = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CAR_W-1:0] CAR_LAST  = CAR_W'(CARRIER_DIV - 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        START    = 3'd2,
        DATA     = 3'd3,
        STOP     = 3'd4
    } state_t;

    state_t                state_r, state_nx_s;
    logic [CLK_W-1:0]      clk_cnt_r, clk_cnt_nx_s;
    logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_nx_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_nx_s;
    logic [CAR_W-1:0]      car_cnt_r, car_cnt_nx_s;
    logic                  phase_r, phase_nx_s;
    logic                  mod_out_r, busy_r, frame_done_r;
    logic                  done_nx_s, sym_nx_s, sym_end_s, accept_s;

    assign tx_ready   = (state_r == IDLE) && enable && !rst;
    assign accept_s   = tx_valid && tx_ready;
    assign sym_end_s  = (clk_cnt_r == CLK_LAST);
    assign mod_out    = mod_out_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Next-state logic; outputs are derived from next values so they register in step with the FSM
    always_comb begin
        state_nx_s   = state_r;
        clk_cnt_nx_s = clk_cnt_r;
        bit_cnt_nx_s = bit_cnt_r;
        shift_nx_s   = shift_r;
        car_cnt_nx_s = car_cnt_r;
        phase_nx_s   = phase_r;
        done_nx_s    = 1'b0;
        sym_nx_s     = 1'b0;

        if (state_r == IDLE) begin
            if (accept_s) begin
                state_nx_s   = PREAMBLE;
                clk_cnt_nx_s = CLK_W'(0);
                bit_cnt_nx_s = BIT_W'(0);
                shift_nx_s   = tx_data;
                car_cnt_nx_s = CAR_W'(0);
                phase_nx_s   = 1'b1;
            end else begin
                state_nx_s = IDLE;
            end
        end else begin
            // carrier is free-running for the whole frame, never realigned per symbol
            if (car_cnt_r == CAR_LAST) begin
                car_cnt_nx_s = CAR_W'(0);
                phase_nx_s   = ~phase_r;
            end else begin
                car_cnt_nx_s = car_cnt_r + CAR_W'(1);
            end

            if (sym_end_s) begin
                clk_cnt_nx_s = CLK_W'(0);
            end else begin
                clk_cnt_nx_s = clk_cnt_r + CLK_W'(1);
            end

            case (state_r)
                PREAMBLE: begin
                    if (sym_end_s && (bit_cnt_r == PRE_LAST)) begin
                        state_nx_s   = START;
                        bit_cnt_nx_s = BIT_W'(0);
                    end else if (sym_end_s) begin
                        bit_cnt_nx_s = bit_cnt_r + BIT_W'(1);
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r;
                    end
                end
                START: begin
                    if (sym_end_s) begin
                        state_nx_s   = DATA;
                        bit_cnt_nx_s = BIT_W'(0);
                    end else begin
                        state_nx_s = START;
                    end
                end
                DATA: begin
                    if (sym_end_s) begin
                        shift_nx_s = shift_r >> 1;
                        if (bit_cnt_r == DATA_LAST) begin
                            state_nx_s   = STOP;
                            bit_cnt_nx_s = BIT_W'(0);
                        end else begin
                            bit_cnt_nx_s = bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        state_nx_s = DATA;
                    end
                end
                STOP: begin
                    if (sym_end_s) begin
                        state_nx_s   = IDLE;
                        done_nx_s    = 1'b1;
                        car_cnt_nx_s = CAR_W'(0);
                        phase_nx_s   = 1'b0;
                    end else begin
                        state_nx_s = STOP;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end

        case (state_nx_s)
            PREAMBLE: sym_nx_s = ~bit_cnt_nx_s[0];
            START:    sym_nx_s = 1'b1;
            DATA:     sym_nx_s = shift_nx_s[0];
            default:  sym_nx_s = 1'b0;
        endcase
    end

    // State, counter and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            clk_cnt_r    <= CLK_W'(0);
            bit_cnt_r    <= BIT_W'(0);
            shift_r      <= {DATA_WIDTH{1'b0}};
            car_cnt_r    <= CAR_W'(0);
            phase_r      <= 1'b0;
            mod_out_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            clk_cnt_r    <= clk_cnt_nx_s;
            bit_cnt_r    <= bit_cnt_nx_s;
            shift_r      <= shift_nx_s;
            car_cnt_r    <= car_cnt_nx_s;
            phase_r      <= phase_nx_s;
            mod_out_r    <= sym_nx_s & phase_nx_s;
            busy_r       <= (state_nx_s != IDLE);
            frame_done_r <= done_nx_s;
        end
    end

endmodule
